// File: rtl/instr_encode.sv
// Packs decoded instruction fields into 16-bit words and streams them through a
// small FIFO into consecutive instruction-memory addresses until the last address fills.
module instr_encode #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [2:0]        dst,
    input  logic [2:0]        src1,
    input  logic [2:0]        src2,
    input  logic [5:0]        offset,
    input  logic [7:0]        imm,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              full,
    output logic              illegal
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_RUN, ST_FULL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_illegal;

    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_op_illegal;
    logic        w_last_addr;
    logic [15:0] w_word;

    function automatic logic [15:0] encode(input logic [3:0] f_op, input logic [2:0] f_dst,
                                           input logic [2:0] f_src1, input logic [2:0] f_src2,
                                           input logic [5:0] f_off, input logic [7:0] f_imm);
        case (f_op)
            4'd0, 4'd1, 4'd2: return {f_op, f_dst, f_src1, f_src2, 3'b000};
            4'd3, 4'd5:       return {f_op, f_src2, f_src1, f_off};
            4'd4:             return {f_op, f_dst, f_src1, f_off};
            4'd6, 4'd7:       return {f_op, f_dst, 1'b0, f_imm};
            4'd8:             return {f_op, 4'b0000, f_imm};
            4'd15:            return 16'hF000;
            default:          return 16'h0000;
        endcase
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] f_op);
        return (f_op >= 4'd9) && (f_op <= 4'd14);
    endfunction

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_op_illegal = op_is_illegal(op);
    assign w_word       = encode(op, dst, src1, src2, offset, imm);
    assign w_hs         = in_valid && in_ready;
    assign w_push       = w_hs && !w_op_illegal;
    assign w_pop        = mem_we && mem_ready && !clear;
    assign w_last_addr  = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN && w_pop && w_last_addr) begin
            w_state_nxt = ST_FULL;
        end
    end

    always_comb begin
        in_ready = !w_fifo_full && (r_state == ST_RUN) && !clear;
        mem_we   = (r_state == ST_RUN) && !w_fifo_empty;
        full     = (r_state == ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_word;
        end
    end

    // clear overrides both the push and the pop of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_addr    <= '0;
            r_illegal <= 1'b0;
        end else if (clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_addr    <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (!w_last_addr) begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end
            if (w_hs && w_op_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign mem_wdata = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign mem_addr  = r_addr;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: encoding table, back-pressure, reset and wrap sequences,
// plus random traffic checked cycle by cycle against a queue-based reference model.
module tb_instr_encode;

    localparam int FD    = 4;
    localparam int A_MAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, clear, mem_we, mem_ready, full, illegal;
    logic [3:0] op;
    logic [2:0] dst, src1, src2;
    logic [5:0] offset;
    logic [7:0] imm;
    logic [7:0] mem_addr;
    logic [15:0] mem_wdata;

    logic        b_in_valid, b_in_ready, b_clear, b_mem_we, b_mem_ready, b_full, b_illegal;
    logic [3:0]  b_op;
    logic [1:0]  b_mem_addr;
    logic [15:0] b_mem_wdata;

    instr_encode #(.ADDR_W(8), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dst(dst), .src1(src1), .src2(src2), .offset(offset), .imm(imm), .clear(clear),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .full(full), .illegal(illegal)
    );

    instr_encode #(.ADDR_W(2), .FIFO_DEPTH(FD)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
        .dst(3'd0), .src1(3'd0), .src2(3'd0), .offset(6'd0), .imm(8'd0), .clear(b_clear),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(b_mem_ready), .full(b_full), .illegal(b_illegal)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field weights.
    function automatic logic [15:0] ref_word(input int o, input int d, input int s1,
                                             input int s2, input int off, input int im);
        int w;
        w = o * 4096;
        if (o <= 2)                w += d * 512 + s1 * 64 + s2 * 8;
        else if (o == 3 || o == 5) w += s2 * 512 + s1 * 64 + off;
        else if (o == 4)           w += d * 512 + s1 * 64 + off;
        else if (o == 6 || o == 7) w += d * 512 + im;
        else if (o == 8)           w += im;
        return 16'(w);
    endfunction

    logic [15:0] q[$];
    int          m_addr = 0;
    bit          m_full = 0;
    bit          m_ill  = 0;
    int          a_wr   = 0;

    task automatic model_reset();
        q.delete();
        m_addr = 0;
        m_full = 0;
        m_ill  = 0;
    endtask

    always @(negedge clk) begin : mon_a
        int sz;
        bit e_ready, e_we, pop, hs;
        sz      = q.size();
        e_ready = (sz < FD) && !m_full && !clear;
        e_we    = !m_full && (sz > 0);
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("full", 32'(full), 32'(m_full));
        chk("illegal", 32'(illegal), 32'(m_ill));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(q[0]));
        if (mem_we && mem_ready) a_wr++;
        if (rst_n) begin
            if (clear) begin
                model_reset();
            end else begin
                pop = e_we && mem_ready;
                hs  = in_valid && e_ready;
                if (pop) begin
                    void'(q.pop_front());
                    if (m_addr == A_MAX) m_full = 1;
                    else m_addr++;
                end
                if (hs) begin
                    if (op >= 4'd9 && op <= 4'd14) m_ill = 1;
                    else q.push_back(ref_word(int'(op), int'(dst), int'(src1), int'(src2),
                                              int'(offset), int'(imm)));
                end
            end
        end
    end

    int b_wcount = 0;
    always @(negedge clk) begin
        if (b_mem_we && b_mem_ready) begin
            chk("small_addr", 32'(b_mem_addr), 32'(b_wcount));
            chk("small_wdata", 32'(b_mem_wdata), 32'h0000F000);
            b_wcount++;
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  d, s1, s2;
        logic [5:0]  off;
        logic [7:0]  im;
        logic        legal;
        logic [15:0] word;
        int          addr;
    } vec_t;
    vec_t tbl[11];

    task automatic set_fields(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [5:0] off, input logic [7:0] im);
        op = o; dst = d; src1 = s1; src2 = s2; offset = off; imm = im; in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name, input int bound);
        bit acc;
        acc = 0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL %s: handshake got none expected accept within %0d cycles", name, bound);
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc, wr0;
        tbl[0]  = '{4'd0,  3'd3, 3'd5, 3'd6, 6'h3F, 8'hFF, 1'b1, 16'h0770, 0};
        tbl[1]  = '{4'd2,  3'd1, 3'd2, 3'd7, 6'h2A, 8'h5A, 1'b1, 16'h22B8, 1};
        tbl[2]  = '{4'd4,  3'd2, 3'd1, 3'd5, 6'h2A, 8'hFF, 1'b1, 16'h446A, 2};
        tbl[3]  = '{4'd5,  3'd3, 3'd0, 3'd7, 6'h3F, 8'h77, 1'b1, 16'h5E3F, 3};
        tbl[4]  = '{4'd7,  3'd4, 3'd7, 3'd7, 6'h3F, 8'hA5, 1'b1, 16'h78A5, 4};
        tbl[5]  = '{4'd8,  3'd7, 3'd7, 3'd7, 6'h3F, 8'h10, 1'b1, 16'h8010, 5};
        tbl[6]  = '{4'd15, 3'd7, 3'd7, 3'd7, 6'h3F, 8'hFF, 1'b1, 16'hF000, 6};
        tbl[7]  = '{4'd10, 3'd1, 3'd1, 3'd1, 6'h01, 8'h01, 1'b0, 16'h0000, 7};
        tbl[8]  = '{4'd6,  3'd1, 3'd6, 3'd5, 6'h3F, 8'h01, 1'b1, 16'h6201, 7};
        tbl[9]  = '{4'd3,  3'd5, 3'd4, 3'd2, 6'h15, 8'hFF, 1'b1, 16'h3515, 8};
        tbl[10] = '{4'd1,  3'd7, 3'd7, 3'd7, 6'h3F, 8'hFF, 1'b1, 16'h1FF8, 9};

        rst_n = 1'b0; in_valid = 0; clear = 0; mem_ready = 1'b1;
        op = 0; dst = 0; src1 = 0; src2 = 0; offset = 0; imm = 0;
        b_in_valid = 0; b_clear = 0; b_mem_ready = 1'b1; b_op = 4'hF;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            set_fields(tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].off, tbl[i].im);
            wait_accept("tbl_accept", 10);
            @(negedge clk);
            if (tbl[i].legal) begin
                chk("tbl_we", 32'(mem_we), 32'd1);
                chk("tbl_word", 32'(mem_wdata), 32'(tbl[i].word));
            end else begin
                chk("tbl_illegal_we", 32'(mem_we), 32'd0);
                chk("tbl_illegal_flag", 32'(illegal), 32'd1);
            end
            chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].addr));
        end
        @(negedge clk);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // Back-pressure: four accepts fill the FIFO while memory stalls.
        do_clear();
        mem_ready = 1'b0;
        wr0 = a_wr;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            set_fields(4'd0, 3'(k), 3'(k + 1), 3'(k + 2), 6'd0, 8'd0);
            wait_accept("bp_accept", 10);
        end
        @(posedge clk); #1;
        set_fields(4'd0, 3'd4, 3'd5, 3'd6, 6'd0, 8'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_we_held", 32'(mem_we), 32'd1);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        wait_accept("bp_accept5", 10);
        @(posedge clk); #1;
        set_fields(4'd0, 3'd5, 3'd6, 3'd7, 6'd0, 8'd0);
        wait_accept("bp_accept6", 10);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_write_count", 32'(a_wr - wr0), 32'd6);
        chk("bp_final_addr", 32'(mem_addr), 32'd6);

        // Random traffic with occasional clear.
        do_clear();
        repeat (400) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            op        = 4'($urandom_range(0, 15));
            dst       = 3'($urandom);
            src1      = 3'($urandom);
            src2      = 3'($urandom);
            offset    = 6'($urandom);
            imm       = 8'($urandom);
        end
        @(posedge clk); #1 in_valid = 0; clear = 0; mem_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Reset with three words buffered.
        do_clear();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            set_fields(4'd8, 3'd0, 3'd0, 3'd0, 6'd0, 8'(k + 1));
            wait_accept("rst_accept", 10);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        set_fields(4'd6, 3'd2, 3'd0, 3'd0, 6'd0, 8'h33);
        wait_accept("midrst_accept", 10);
        @(negedge clk);
        chk("midrst_post_we", 32'(mem_we), 32'd1);
        chk("midrst_post_addr", 32'(mem_addr), 32'd0);
        chk("midrst_post_word", 32'(mem_wdata), 32'h6433);

        // Wrap to full on the 4-word memory.
        acc = 0;
        @(posedge clk); #1 b_in_valid = 1'b1;
        for (int i = 0; i < 50 && acc < 5; i++) begin
            @(negedge clk);
            if (b_in_ready) acc++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        chk("wrap_accepts", 32'(acc), 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrap_writes", 32'(b_wcount), 32'd4);
        chk("wrap_full", 32'(b_full), 32'd1);
        chk("wrap_in_ready", 32'(b_in_ready), 32'd0);
        chk("wrap_we", 32'(b_mem_we), 32'd0);
        chk("wrap_addr", 32'(b_mem_addr), 32'd3);
        @(posedge clk); #1 b_clear = 1'b1;
        @(posedge clk); #1 b_clear = 1'b0;
        @(negedge clk);
        chk("wrap_clr_addr", 32'(b_mem_addr), 32'd0);
        chk("wrap_clr_full", 32'(b_full), 32'd0);
        chk("wrap_clr_in_ready", 32'(b_in_ready), 32'd1);
        chk("wrap_clr_we", 32'(b_mem_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
